// File: rtl/blram_dp.sv
`default_nettype none
// ============================================================================
// Module   : blram_dp
// Purpose  : True dual-port block RAM with byte-lane write enables,
//            1- or 2-cycle registered reads, selectable same-port
//            read-during-write behaviour and an optional engine that zeroes
//            the whole array after reset.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            a_re/b_re, a_we/b_we   - read / write requests per port
//            a_be/b_be              - byte-lane write enables (lane i = 8i+7:8i)
//            a_addr/b_addr          - word address, wraps modulo DEPTH
//            a_din/b_din            - write data
//            a_dout/b_dout          - registered read data (holds when idle)
//            a_rvalid/b_rvalid      - one-cycle pulse per completed read
//            busy                   - array unavailable (reset or clear running)
// Revision : 1.0 - initial release
// ============================================================================
module blram_dp #(
  parameter int SIZE       = 10,
  parameter int DEPTH      = 1024,
  parameter int WIDTH      = 32,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_re,
  input  logic               a_we,
  input  logic [WIDTH/8-1:0] a_be,
  input  logic [SIZE-1:0]    a_addr,
  input  logic [WIDTH-1:0]   a_din,
  output logic [WIDTH-1:0]   a_dout,
  output logic               a_rvalid,
  input  logic               b_re,
  input  logic               b_we,
  input  logic [WIDTH/8-1:0] b_be,
  input  logic [SIZE-1:0]    b_addr,
  input  logic [WIDTH-1:0]   b_din,
  output logic [WIDTH-1:0]   b_dout,
  output logic               b_rvalid,
  output logic               busy
);

  localparam int            NB        = WIDTH / 8;
  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // Clear engine
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          clear_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Any reset, including one in the middle of a clear, restarts at word 0.
      state_q    <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign clear_we = (state_q == ST_CLEAR) && !rst;
  assign busy     = rst || (state_q == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Port bundling (index 0 = port A, 1 = port B)
  // --------------------------------------------------------------------------
  logic [1:0]       re_v, we_v;
  logic [NB-1:0]    be_v  [2];
  logic [AW-1:0]    idx_v [2];
  logic [WIDTH-1:0] din_v [2];
  logic             unused_addr_bits;

  assign re_v     = {b_re, a_re};
  assign we_v     = {b_we, a_we};
  assign be_v[0]  = a_be;
  assign be_v[1]  = b_be;
  assign idx_v[0] = a_addr[AW-1:0];
  assign idx_v[1] = b_addr[AW-1:0];
  assign din_v[0] = a_din;
  assign din_v[1] = b_din;

  // Address bits above log2(DEPTH) simply wrap.
  assign unused_addr_bits = ^{a_addr, b_addr};

  // --------------------------------------------------------------------------
  // Array and write merging
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] old_word [2];
  logic [WIDTH-1:0] own_word [2];
  logic [WIDTH-1:0] a_wr_word;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      old_word[p] = mem_q[idx_v[p]];
      own_word[p] = old_word[p];
      for (int i = 0; i < NB; i++) begin
        if (we_v[p] && be_v[p][i]) begin
          own_word[p][8*i +: 8] = din_v[p][8*i +: 8];
        end
      end
    end
    // On a shared address, start from B's merged word so lanes that only B
    // enables survive, then let A's enabled lanes win.
    a_wr_word = ((idx_v[0] == idx_v[1]) && we_v[1]) ? own_word[1] : old_word[0];
    for (int i = 0; i < NB; i++) begin
      if (we_v[0] && be_v[0][i]) begin
        a_wr_word[8*i +: 8] = din_v[0][8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem_q[clr_addr_q] <= '0;
    end else if (!busy) begin
      if (we_v[1] && (|be_v[1])) begin
        mem_q[idx_v[1]] <= own_word[1];
      end
      // Issued after B so that A's merged word is the one kept on a collision.
      if (we_v[0] && (|be_v[0])) begin
        mem_q[idx_v[0]] <= a_wr_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipelines
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [WIDTH-1:0] dout_q;
    logic             rvalid_q;
    logic             req;
    logic [WIDTH-1:0] rd_word;

    assign req = re_v[p] && !busy;
    // Write-first returns this port's own merge only; the other port's write
    // in the same cycle is never visible here.
    assign rd_word = (RDW_MODE != 0) ? own_word[p] : old_word[p];

    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s1_data_q;
      logic             s1_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_data_q  <= '0;
          s1_valid_q <= 1'b0;
          dout_q     <= '0;
          rvalid_q   <= 1'b0;
        end else begin
          s1_valid_q <= req;
          if (req) begin
            s1_data_q <= rd_word;
          end
          rvalid_q <= s1_valid_q;
          if (s1_valid_q) begin
            dout_q <= s1_data_q;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q   <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= req;
          if (req) begin
            dout_q <= rd_word;
          end
        end
      end
    end
  end

  assign a_dout   = g_port[0].dout_q;
  assign a_rvalid = g_port[0].rvalid_q;
  assign b_dout   = g_port[1].dout_q;
  assign b_rvalid = g_port[1].rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_blram_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_blram_dp
// Purpose  : Self-checking bench for blram_dp. Two instances:
//            u_dut0 - SIZE=14, DEPTH=1024, RD_LAT=1, read-first, no clear
//            u_dut1 - SIZE=6,  DEPTH=16,   RD_LAT=2, write-first, clear on reset
//            Each is compared against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  // ---------------- instance 0 ----------------
  logic        rst0;
  logic        a0_re, a0_we, b0_re, b0_we;
  logic [3:0]  a0_be, b0_be;
  logic [13:0] a0_addr, b0_addr;
  logic [31:0] a0_din, b0_din, a0_dout, b0_dout;
  logic        a0_rvalid, b0_rvalid, busy0;

  blram_dp #(.SIZE(14), .DEPTH(1024), .WIDTH(32), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(0)) u_dut0 (
    .clk(clk), .rst(rst0),
    .a_re(a0_re), .a_we(a0_we), .a_be(a0_be), .a_addr(a0_addr), .a_din(a0_din),
    .a_dout(a0_dout), .a_rvalid(a0_rvalid),
    .b_re(b0_re), .b_we(b0_we), .b_be(b0_be), .b_addr(b0_addr), .b_din(b0_din),
    .b_dout(b0_dout), .b_rvalid(b0_rvalid),
    .busy(busy0)
  );

  // ---------------- instance 1 ----------------
  logic        rst1;
  logic        a1_re, a1_we, b1_re, b1_we;
  logic [3:0]  a1_be, b1_be;
  logic [5:0]  a1_addr, b1_addr;
  logic [31:0] a1_din, b1_din, a1_dout, b1_dout;
  logic        a1_rvalid, b1_rvalid, busy1;

  blram_dp #(.SIZE(6), .DEPTH(16), .WIDTH(32), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .a_re(a1_re), .a_we(a1_we), .a_be(a1_be), .a_addr(a1_addr), .a_din(a1_din),
    .a_dout(a1_dout), .a_rvalid(a1_rvalid),
    .b_re(b1_re), .b_we(b1_we), .b_be(b1_be), .b_addr(b1_addr), .b_din(b1_din),
    .b_dout(b1_dout), .b_rvalid(b1_rvalid),
    .busy(busy1)
  );

  // ---------------- reference model ----------------
  logic [31:0] m0 [1024];
  logic [31:0] m1 [16];
  logic [31:0] e0_ad = '0, e0_bd = '0, e1_ad = '0, e1_bd = '0;
  logic        e0_arv = 1'b0, e0_brv = 1'b0, e0_busy = 1'b1;
  logic        e1_arv = 1'b0, e1_brv = 1'b0, e1_busy = 1'b1;
  // Instance 1: reads waiting one more cycle, and words left to clear.
  logic        p1_av = 1'b0, p1_bv = 1'b0;
  logic [31:0] p1_ad = '0, p1_bd = '0;
  int          clr_left1 = 0;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic we,
                                        input logic [3:0] be, input logic [31:0] din);
    logic [31:0] r;
    r = old;
    if (we) for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  // One clock of instance 0: read-first, one-cycle latency, no clear.
  task automatic step0();
    int ia, ib;
    logic ra, rb;
    logic [31:0] wa, wb;
    ia = int'(a0_addr) % 1024;
    ib = int'(b0_addr) % 1024;
    ra = a0_re && !rst0;
    rb = b0_re && !rst0;
    wa = m0[ia];
    wb = m0[ib];
    if (!rst0) begin
      if (ia == ib) m0[ia] = lanes(lanes(m0[ia], b0_we, b0_be, b0_din), a0_we, a0_be, a0_din);
      else begin
        m0[ia] = lanes(m0[ia], a0_we, a0_be, a0_din);
        m0[ib] = lanes(m0[ib], b0_we, b0_be, b0_din);
      end
    end
    @(posedge clk); #1;
    e0_busy = rst0;
    if (rst0) begin
      e0_ad = '0; e0_bd = '0; e0_arv = 1'b0; e0_brv = 1'b0;
    end else begin
      e0_arv = ra; e0_brv = rb;
      if (ra) e0_ad = wa;
      if (rb) e0_bd = wb;
    end
  endtask

  // One clock of instance 1: write-first, two-cycle latency, clears for 16
  // cycles after every reset release.
  task automatic step1();
    int ia, ib;
    logic bz, ra, rb;
    logic [31:0] wa, wb;
    bz = rst1 || (clr_left1 > 0);
    ia = int'(a1_addr) % 16;
    ib = int'(b1_addr) % 16;
    ra = a1_re && !bz;
    rb = b1_re && !bz;
    wa = lanes(m1[ia], a1_we, a1_be, a1_din);
    wb = lanes(m1[ib], b1_we, b1_be, b1_din);
    if (!bz) begin
      if (ia == ib) m1[ia] = lanes(lanes(m1[ia], b1_we, b1_be, b1_din), a1_we, a1_be, a1_din);
      else begin
        m1[ia] = lanes(m1[ia], a1_we, a1_be, a1_din);
        m1[ib] = lanes(m1[ib], b1_we, b1_be, b1_din);
      end
    end
    @(posedge clk); #1;
    if (rst1) begin
      clr_left1 = 16;
      e1_ad = '0; e1_bd = '0; e1_arv = 1'b0; e1_brv = 1'b0;
      p1_av = 1'b0; p1_bv = 1'b0;
    end else begin
      if (clr_left1 > 0) begin
        clr_left1--;
        if (clr_left1 == 0) for (int k = 0; k < 16; k++) m1[k] = '0;
      end
      e1_arv = p1_av; e1_brv = p1_bv;
      if (p1_av) e1_ad = p1_ad;
      if (p1_bv) e1_bd = p1_bd;
      p1_av = ra; p1_ad = wa;
      p1_bv = rb; p1_bd = wb;
    end
    e1_busy = rst1 || (clr_left1 > 0);
  endtask

  task automatic idle0();
    a0_re = 0; a0_we = 0; a0_be = '0; a0_addr = '0; a0_din = '0;
    b0_re = 0; b0_we = 0; b0_be = '0; b0_addr = '0; b0_din = '0;
  endtask

  task automatic idle1();
    a1_re = 0; a1_we = 0; a1_be = '0; a1_addr = '0; a1_din = '0;
    b1_re = 0; b1_we = 0; b1_be = '0; b1_addr = '0; b1_din = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst0 = 1; rst1 = 1;
    idle0(); idle1();
    a0_re = 1; a0_addr = 14'd5; b0_re = 1; a1_re = 1; b1_re = 1;
    repeat (3) step0();
    nchecks++; if (busy0 !== 1'b1) begin nerrors++; $display("FAIL rst_busy0: got %b want 1", busy0); end
    nchecks++; if ({a0_rvalid, b0_rvalid} !== 2'b00) begin nerrors++; $display("FAIL rst_rvalid0: got %b want 00", {a0_rvalid, b0_rvalid}); end
    nchecks++; if ({a0_dout, b0_dout} !== 64'd0) begin nerrors++; $display("FAIL rst_dout0: got %h want 0", {a0_dout, b0_dout}); end
    nchecks++; if (busy1 !== 1'b1) begin nerrors++; $display("FAIL rst_busy1: got %b want 1", busy1); end
    nchecks++; if ({a1_rvalid, b1_rvalid} !== 2'b00) begin nerrors++; $display("FAIL rst_rvalid1: got %b want 00", {a1_rvalid, b1_rvalid}); end
    nchecks++; if ({a1_dout, b1_dout} !== 64'd0) begin nerrors++; $display("FAIL rst_dout1: got %h want 0", {a1_dout, b1_dout}); end
    idle1();
    rst0 = 0; idle0();
    step0();
    nchecks++; if (busy0 !== 1'b0) begin nerrors++; $display("FAIL rst_release_busy0: got %b want 0", busy0); end
  endtask

  task automatic test_fill0();
    for (int k = 0; k < 512; k++) begin
      a0_we = 1; a0_be = 4'hF; a0_addr = 14'(k);       a0_din = $urandom;
      b0_we = 1; b0_be = 4'hF; b0_addr = 14'(k + 512); b0_din = $urandom;
      step0();
    end
    idle0();
  endtask

  task automatic test_read_latency();
    a0_we = 1; a0_be = 4'hF; a0_addr = 14'd50; a0_din = 32'd4; step0(); idle0();
    a0_re = 1; a0_addr = 14'd50; step0(); idle0();
    nchecks++; if (a0_rvalid !== 1'b1 || a0_dout !== 32'd4) begin nerrors++; $display("FAIL rd_lat1: got rv=%b d=%h want rv=1 d=00000004", a0_rvalid, a0_dout); end
    step0();
    nchecks++; if (a0_rvalid !== 1'b0 || a0_dout !== 32'd4) begin nerrors++; $display("FAIL rd_pulse_hold: got rv=%b d=%h want rv=0 d=00000004", a0_rvalid, a0_dout); end
  endtask

  task automatic test_dual_write();
    a0_we = 1; a0_be = 4'hF; a0_addr = 14'd3; a0_din = 32'd0; step0(); idle0();
    a0_we = 1; a0_be = 4'b0011; a0_addr = 14'd3; a0_din = 32'hFFFF_FFFF;
    b0_we = 1; b0_be = 4'b1111; b0_addr = 14'd3; b0_din = 32'h1234_5678;
    step0(); idle0();
    a0_re = 1; a0_addr = 14'd3; step0(); idle0();
    nchecks++; if (a0_dout !== 32'h1234_FFFF) begin nerrors++; $display("FAIL dual_write: got %h want 1234ffff", a0_dout); end
  endtask

  task automatic test_rdw0();
    a0_we = 1; a0_be = 4'hF; a0_addr = 14'd9; a0_din = 32'd5; step0(); idle0();
    a0_re = 1; a0_we = 1; a0_be = 4'hF; a0_addr = 14'd9; a0_din = 32'd6;
    b0_re = 1; b0_addr = 14'd9;
    step0(); idle0();
    nchecks++; if (a0_dout !== 32'd5) begin nerrors++; $display("FAIL rdw_readfirst_a: got %h want 00000005", a0_dout); end
    nchecks++; if (b0_dout !== 32'd5) begin nerrors++; $display("FAIL rdw_cross_b0: got %h want 00000005", b0_dout); end
    a0_re = 1; a0_addr = 14'd9; step0(); idle0();
    nchecks++; if (a0_dout !== 32'd6) begin nerrors++; $display("FAIL rdw_write_landed: got %h want 00000006", a0_dout); end
  endtask

  task automatic test_wrap();
    a0_we = 1; a0_be = 4'hF; a0_addr = 14'd1074; a0_din = 32'd9; step0(); idle0();
    a0_re = 1; a0_addr = 14'd50; b0_re = 1; b0_addr = 14'(50 + 15 * 1024); step0(); idle0();
    nchecks++; if (a0_dout !== 32'd9) begin nerrors++; $display("FAIL wrap_a: got %h want 00000009", a0_dout); end
    nchecks++; if (b0_dout !== 32'd9) begin nerrors++; $display("FAIL wrap_b: got %h want 00000009", b0_dout); end
  endtask

  task automatic test_random0();
    for (int n = 0; n < 400; n++) begin
      a0_re = 1'($urandom_range(0, 1)); a0_we = 1'($urandom_range(0, 1)); a0_be = 4'($urandom);
      a0_addr = 14'($urandom_range(0, 7) + 1024 * $urandom_range(0, 15)); a0_din = $urandom;
      b0_re = 1'($urandom_range(0, 1)); b0_we = 1'($urandom_range(0, 1)); b0_be = 4'($urandom);
      b0_addr = 14'($urandom_range(0, 7) + 1024 * $urandom_range(0, 15)); b0_din = $urandom;
      step0();
      nchecks++; if (a0_rvalid !== e0_arv) begin nerrors++; $display("FAIL rand0_a_rvalid: got %b want %b", a0_rvalid, e0_arv); end
      nchecks++; if (a0_dout !== e0_ad) begin nerrors++; $display("FAIL rand0_a_dout: got %h want %h", a0_dout, e0_ad); end
      nchecks++; if (b0_rvalid !== e0_brv) begin nerrors++; $display("FAIL rand0_b_rvalid: got %b want %b", b0_rvalid, e0_brv); end
      nchecks++; if (b0_dout !== e0_bd) begin nerrors++; $display("FAIL rand0_b_dout: got %h want %h", b0_dout, e0_bd); end
    end
    idle0();
  endtask

  task automatic test_reset_keep0();
    for (int k = 0; k < 4; k++) begin
      a0_we = 1; a0_be = 4'hF; a0_addr = 14'(100 + k); a0_din = $urandom; step0();
    end
    idle0();
    rst0 = 1; a0_re = 1; a0_we = 1; a0_be = 4'hF; a0_addr = 14'd100; a0_din = 32'hDEAD_BEEF;
    step0(); step0();
    nchecks++; if (a0_rvalid !== 1'b0 || busy0 !== 1'b1) begin nerrors++; $display("FAIL rst0_ignore: got rv=%b busy=%b want rv=0 busy=1", a0_rvalid, busy0); end
    rst0 = 0; idle0();
    for (int k = 0; k < 4; k++) begin
      a0_re = 1; a0_addr = 14'(100 + k); step0();
      nchecks++; if (a0_rvalid !== 1'b1 || a0_dout !== e0_ad) begin nerrors++; $display("FAIL keep_after_rst: got rv=%b d=%h want rv=1 d=%h", a0_rvalid, a0_dout, e0_ad); end
    end
    idle0();
  endtask

  task automatic test_clear();
    int n;
    rst1 = 1; idle1(); step1(); step1();
    rst1 = 0;
    for (int k = 0; k < 16; k++) begin
      step1();
      nchecks++; if (busy1 !== e1_busy) begin nerrors++; $display("FAIL clr1_busy: got %b want %b", busy1, e1_busy); end
    end
    // Preload, then leave one read in flight across a reset.
    a1_we = 1; a1_be = 4'hF; a1_addr = 6'd15; a1_din = 32'd3; step1(); idle1();
    a1_re = 1; a1_addr = 6'd15; step1(); idle1();
    rst1 = 1; step1();
    nchecks++; if (a1_rvalid !== 1'b0) begin nerrors++; $display("FAIL inflight_discard: got %b want 0", a1_rvalid); end
    rst1 = 0;
    for (int k = 0; k < 8; k++) begin
      step1();
      nchecks++; if (a1_rvalid !== 1'b0 || busy1 !== 1'b1) begin nerrors++; $display("FAIL clr_first_half: got rv=%b busy=%b want rv=0 busy=1", a1_rvalid, busy1); end
    end
    rst1 = 1; step1(); rst1 = 0;
    a1_re = 1; a1_we = 1; a1_be = 4'hF; a1_addr = 6'd15; a1_din = 32'h77;
    b1_re = 1; b1_we = 1; b1_be = 4'hF; b1_addr = 6'd0;  b1_din = 32'h55;
    n = 0;
    do begin
      step1(); n++;
      nchecks++; if (a1_rvalid !== e1_arv || busy1 !== e1_busy) begin nerrors++; $display("FAIL clr_busy_window: got rv=%b busy=%b want rv=%b busy=%b", a1_rvalid, busy1, e1_arv, e1_busy); end
    end while (busy1 === 1'b1 && n < 40);
    idle1();
    nchecks++; if (n !== 16) begin nerrors++; $display("FAIL clr_busy_len: got %0d want 16", n); end
    a1_re = 1; a1_addr = 6'd0; b1_re = 1; b1_addr = 6'd15; step1(); idle1(); step1();
    nchecks++; if (a1_rvalid !== 1'b1 || a1_dout !== 32'd0) begin nerrors++; $display("FAIL clr_addr0: got rv=%b d=%h want rv=1 d=0", a1_rvalid, a1_dout); end
    nchecks++; if (b1_rvalid !== 1'b1 || b1_dout !== 32'd0) begin nerrors++; $display("FAIL clr_addr15: got rv=%b d=%h want rv=1 d=0", b1_rvalid, b1_dout); end
  endtask

  task automatic test_lat2_bytes();
    a1_we = 1; a1_be = 4'hF; a1_addr = 6'd7; a1_din = 32'h1122_3344; step1(); idle1();
    a1_we = 1; a1_be = 4'b0101; a1_addr = 6'd7; a1_din = 32'hAABB_CCDD; step1(); idle1();
    a1_re = 1; a1_addr = 6'd7; step1(); idle1();
    nchecks++; if (a1_rvalid !== 1'b0) begin nerrors++; $display("FAIL lat2_early: got %b want 0", a1_rvalid); end
    step1();
    nchecks++; if (a1_rvalid !== 1'b1 || a1_dout !== 32'h11BB_33DD) begin nerrors++; $display("FAIL lat2_bytes: got rv=%b d=%h want rv=1 d=11bb33dd", a1_rvalid, a1_dout); end
    step1();
    nchecks++; if (a1_rvalid !== 1'b0) begin nerrors++; $display("FAIL lat2_pulse: got %b want 0", a1_rvalid); end
  endtask

  task automatic test_rdw1();
    a1_we = 1; a1_be = 4'hF; a1_addr = 6'd9; a1_din = 32'd5; step1(); idle1();
    a1_re = 1; a1_we = 1; a1_be = 4'hF; a1_addr = 6'd9; a1_din = 32'd6;
    b1_re = 1; b1_addr = 6'd9;
    step1(); idle1(); step1();
    nchecks++; if (a1_dout !== 32'd6) begin nerrors++; $display("FAIL rdw_writefirst_a: got %h want 00000006", a1_dout); end
    nchecks++; if (b1_dout !== 32'd5) begin nerrors++; $display("FAIL rdw_cross_b1: got %h want 00000005", b1_dout); end
  endtask

  task automatic test_random1();
    for (int n = 0; n < 400; n++) begin
      rst1 = ($urandom_range(0, 49) == 0);
      a1_re = 1'($urandom_range(0, 1)); a1_we = 1'($urandom_range(0, 1)); a1_be = 4'($urandom);
      a1_addr = 6'($urandom_range(0, 63)); a1_din = $urandom;
      b1_re = 1'($urandom_range(0, 1)); b1_we = 1'($urandom_range(0, 1)); b1_be = 4'($urandom);
      b1_addr = 6'($urandom_range(0, 63)); b1_din = $urandom;
      step1();
      nchecks++; if (a1_rvalid !== e1_arv) begin nerrors++; $display("FAIL rand1_a_rvalid: got %b want %b", a1_rvalid, e1_arv); end
      nchecks++; if (a1_dout !== e1_ad) begin nerrors++; $display("FAIL rand1_a_dout: got %h want %h", a1_dout, e1_ad); end
      nchecks++; if (b1_rvalid !== e1_brv) begin nerrors++; $display("FAIL rand1_b_rvalid: got %b want %b", b1_rvalid, e1_brv); end
      nchecks++; if (b1_dout !== e1_bd) begin nerrors++; $display("FAIL rand1_b_dout: got %h want %h", b1_dout, e1_bd); end
      nchecks++; if (busy1 !== e1_busy) begin nerrors++; $display("FAIL rand1_busy: got %b want %b", busy1, e1_busy); end
    end
    rst1 = 0; idle1();
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) m0[k] = '0;
    for (int k = 0; k < 16; k++)   m1[k] = '0;
    rst0 = 1; rst1 = 1;
    idle0(); idle1();
    test_reset();
    test_fill0();
    test_read_latency();
    test_dual_write();
    test_rdw0();
    test_wrap();
    test_random0();
    test_reset_keep0();
    test_clear();
    test_lat2_bytes();
    test_rdw1();
    test_random1();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/blram_dp.md
BLRAM_DP -- requirements
Module: blram_dp

Interface
REQ-001 Parameter SIZE, default 10: address port width in bits.
REQ-002 Parameter DEPTH, default 1024: number of words; power of two, at most 2^SIZE.
REQ-003 Parameter WIDTH, default 32: data width in bits; multiple of 8; NB = WIDTH/8 byte lanes.
REQ-004 Parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 Parameter RDW_MODE, default 0: same-port read-during-write; 0 = read-first (old data), 1 = write-first (new data).
REQ-006 Parameter CLR_ON_RST, default 0: 1 = zero the whole array after reset.
REQ-007 One clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-008 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-009 Port rst, input, 1: synchronous active-high reset.
REQ-010 Ports a_re and b_re, input, 1 each: read request for port A / port B.
REQ-011 Ports a_we and b_we, input, 1 each: write request.
REQ-012 Ports a_be and b_be, input, NB each: per-byte write enables; lane i covers bits 8i+7:8i.
REQ-013 Ports a_addr and b_addr, input, SIZE each: word address.
REQ-014 Ports a_din and b_din, input, WIDTH each: write data.
REQ-015 Ports a_dout and b_dout, output, WIDTH each: registered read data.
REQ-016 Ports a_rvalid and b_rvalid, output, 1 each: a_dout / b_dout holds the data for a read request.
REQ-017 Port busy, output, 1: array unavailable (reset or clear in progress).

Function
REQ-018 Effective address = addr modulo DEPTH (low log2(DEPTH) bits); upper bits are ignored and wrap with no error.
REQ-019 Write: when we=1 and busy=0, each lane with be[i]=1 is updated at the edge; lanes with be[i]=0 keep their old value; we=1 with be=0 is a no-op.
REQ-020 Read: when re=1 and busy=0, the array is sampled at edge N; with RD_LAT=1, dout and rvalid=1 appear after edge N; with RD_LAT=2, after edge N+1.
REQ-021 rvalid pulses for exactly one cycle per request; dout holds its last value while rvalid=0; back-to-back requests produce one result per cycle.
REQ-022 Same-port re and we in the same cycle at the same address: RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns the merged word (new bytes where be=1, old bytes elsewhere).
REQ-023 Cross-port read of an address the other port writes in the same cycle always returns the pre-write word, regardless of RDW_MODE.
REQ-024 Both ports write the same address in the same cycle: for each lane, port A data wins where a_be[i]=1; port B data is written on lanes where only b_be[i]=1.
REQ-025 When busy=1, re and we are ignored: no array update and no rvalid; requests are not queued.
REQ-026 Clear engine (CLR_ON_RST=1): states IDLE and CLEAR.
- rst=1 forces CLEAR with the address counter at 0.
- After rst falls, one word (all lanes) is zeroed per cycle at addresses 0..DEPTH-1.
- The cycle after address DEPTH-1 is written, the engine enters IDLE.
REQ-027 busy is 1 while rst=1 and during CLEAR; with CLR_ON_RST=1 it drops exactly DEPTH cycles after rst falls.
REQ-028 With CLR_ON_RST=0, busy follows rst only, and array contents survive reset, including simulation-time preloads.

Reset
REQ-029 While rst=1: a_dout=0, b_dout=0, a_rvalid=0, b_rvalid=0, busy=1, and every read pipeline stage is cleared.
REQ-030 A read in flight when rst rises is discarded; no rvalid is produced for it after reset.
REQ-031 rst asserted during CLEAR restarts the clear at address 0.

Verification
REQ-032 Default parameters, preload mem[50]=4; a_re=1, a_addr=50 at edge N -> a_dout=4, a_rvalid=1 after edge N, and rvalid=0 the following cycle.
REQ-033 RD_LAT=2, mem[7]=0x11223344; A writes be=0b0101, din=0xAABBCCDD to address 7, then reads address 7 -> 0x11BB33DD, with rvalid two cycles after the read sample.
REQ-034 In the same cycle, A writes 0xFFFFFFFF (be=0b0011) and B writes 0x12345678 (be=0b1111) to address 3, old word 0 -> mem[3]=0x1234FFFF.
REQ-035 Old word at address 9 = 5; A re+we 9 with din=6 in one cycle, while B reads 9 the same cycle -> RDW_MODE=0: a_dout=5; RDW_MODE=1: a_dout=6; b_dout=5 in both modes.
REQ-036 SIZE=14, DEPTH=1024: A writes address 1074 with value 9 -> a read of address 50 returns 9.
REQ-037 CLR_ON_RST=1, DEPTH=16, preload mem[15]=3; release rst, re-pulse rst at clear address 8, then release -> busy stays high 16 cycles after the final release, writes during busy are ignored, and reads of addresses 0 and 15 then return 0.
